imem_loader: RTL and testbench

Instruction memory with a byte-serial program-load port, sitting directly upstream of the cpu core. It serves the 19-bit instruction addressed by the core's 32-bit PC. It accepts a program image as a length-prefixed byte stream and packs each three bytes into one instruction word. While loading, it holds the core in reset, then releases it so the core starts fetching at PC 0.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Instruction memory for the cpu core with a byte-serial program-load port.
//   A load is a 16-bit big-endian word count N followed by N three-byte
//   big-endian words (19 significant bits each). The core is held in reset
//   for the whole load, then released for one clean reset cycle so its PC
//   starts at 0.
//
// Ports
//   CLK          sole clock, rising edge
//   RESET        synchronous active-high reset
//   LOAD_START   single-cycle request to begin (or restart) a program load
//   BYTE_IN      load-stream byte
//   BYTE_VALID   BYTE_IN valid this cycle
//   BYTE_READY   loader accepts a byte this cycle (registered, state only)
//   PC           fetch address from the core
//   INSTRUCTION  instruction at PC, zero when PC is past the loaded program
//   CPU_RESET    drives the core's RESET; low only while the program runs
//   LOAD_DONE    high while a loaded program is running
//   LOAD_ERR     last load declared more than DEPTH words
//   WORD_COUNT   number of valid words in memory
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD_START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  input  logic [31:0] PC,
  output logic [18:0] INSTRUCTION,
  output logic        CPU_RESET,
  output logic        LOAD_DONE,
  output logic        LOAD_ERR,
  output logic [15:0] WORD_COUNT
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR_HI  = 3'd1;
  localparam logic [2:0] HDR_LO  = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] RUN     = 3'd5;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic [1:0]  phase_r;
  logic [10:0] part_r;       // bits [18:8] of the word being assembled
  logic        xfer_s;
  logic        restart_s;
  logic        release_entry_s;
  logic        wr_en_s;
  logic [15:0] entry_len_s;
  logic [18:0] mem [DEPTH];

  // A restart wins over a byte in the same cycle, so the byte is not consumed.
  assign restart_s       = LOAD_START && (state_r != RELEASE);
  assign xfer_s          = BYTE_VALID && BYTE_READY && !LOAD_START;
  assign release_entry_s = (next_state_s == RELEASE) && (state_r != RELEASE);
  // Entry from HDR_LO only happens for an empty program.
  assign entry_len_s     = (state_r == DATA) ? len_r : 16'd0;
  assign wr_en_s         = xfer_s && (state_r == DATA) && (phase_r == 2'd2)
                           && ({1'b0, idx_r} < DEPTH_W);

  // Next-state logic of the load sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (LOAD_START) next_state_s = HDR_HI;
        else            next_state_s = IDLE;
      end
      HDR_HI: begin
        if (LOAD_START)  next_state_s = HDR_HI;
        else if (xfer_s) next_state_s = HDR_LO;
        else             next_state_s = HDR_HI;
      end
      HDR_LO: begin
        if (LOAD_START) next_state_s = HDR_HI;
        else if (xfer_s) begin
          if ({len_r[15:8], BYTE_IN} == 16'd0) next_state_s = RELEASE;
          else                                 next_state_s = DATA;
        end else begin
          next_state_s = HDR_LO;
        end
      end
      DATA: begin
        if (LOAD_START) next_state_s = HDR_HI;
        else if (xfer_s && (phase_r == 2'd2) && (idx_r == len_r - 16'd1))
          next_state_s = RELEASE;
        else
          next_state_s = DATA;
      end
      RELEASE: next_state_s = RUN;
      RUN: begin
        if (LOAD_START) next_state_s = HDR_HI;
        else            next_state_s = RUN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register, registered handshake/core-reset outputs and status flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      BYTE_READY <= 1'b0;
      CPU_RESET  <= 1'b1;
      LOAD_DONE  <= 1'b0;
      LOAD_ERR   <= 1'b0;
      WORD_COUNT <= 16'd0;
    end else begin
      state_r    <= next_state_s;
      BYTE_READY <= (next_state_s == HDR_HI) || (next_state_s == HDR_LO)
                    || (next_state_s == DATA);
      CPU_RESET  <= (next_state_s != RUN);
      LOAD_DONE  <= (next_state_s == RUN);
      if (restart_s) begin
        LOAD_ERR   <= 1'b0;
        WORD_COUNT <= 16'd0;
      end else if (release_entry_s) begin
        LOAD_ERR   <= ({1'b0, entry_len_s} > DEPTH_W);
        WORD_COUNT <= ({1'b0, entry_len_s} > DEPTH_W) ? DEPTH_W[15:0] : entry_len_s;
      end
    end
  end

  // Header capture and word assembly (length, word index, byte phase).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      len_r   <= 16'd0;
      idx_r   <= 16'd0;
      phase_r <= 2'd0;
      part_r  <= 11'd0;
    end else if (restart_s) begin
      idx_r   <= 16'd0;
      phase_r <= 2'd0;
    end else if (xfer_s) begin
      case (state_r)
        HDR_HI: len_r[15:8] <= BYTE_IN;
        HDR_LO: begin
          len_r[7:0] <= BYTE_IN;
          idx_r      <= 16'd0;
          phase_r    <= 2'd0;
        end
        DATA: begin
          case (phase_r)
            2'd0: begin
              part_r[10:8] <= BYTE_IN[2:0];
              phase_r      <= 2'd1;
            end
            2'd1: begin
              part_r[7:0] <= BYTE_IN;
              phase_r     <= 2'd2;
            end
            default: begin
              phase_r <= 2'd0;
              idx_r   <= idx_r + 16'd1;
            end
          endcase
        end
        default: phase_r <= phase_r;
      endcase
    end
  end

  // Instruction storage; words past DEPTH are consumed but never written.
  always_ff @(posedge CLK) begin
    if (wr_en_s) mem[idx_r[ADDR_W-1:0]] <= {part_r, BYTE_IN};
  end

  // Asynchronous fetch, gated so PCs past the program read as zero.
  always_comb begin
    if (PC < {16'd0, WORD_COUNT}) INSTRUCTION = mem[PC[ADDR_W-1:0]];
    else                          INSTRUCTION = 19'd0;
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        LOAD_START = 1'b0;
  logic [7:0]  BYTE_IN = 8'd0;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY;
  logic [31:0] PC = 32'd0;
  logic [18:0] INSTRUCTION;
  logic        CPU_RESET;
  logic        LOAD_DONE;
  logic        LOAD_ERR;
  logic [15:0] WORD_COUNT;

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD_START(LOAD_START), .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY), .PC(PC),
    .INSTRUCTION(INSTRUCTION), .CPU_RESET(CPU_RESET), .LOAD_DONE(LOAD_DONE),
    .LOAD_ERR(LOAD_ERR), .WORD_COUNT(WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  int start_cyc = 0;
  logic [23:0] src_q[$];   // raw three-byte words to send
  logic [18:0] exp_q[$];   // scoreboard: expected memory words, in PC order

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    start_cyc = cyc;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited = 0;
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    while (!BYTE_READY && waited < 20) begin
      tick();
      waited++;
    end
    if (!BYTE_READY) check_eq("ready_timeout", 32'(BYTE_READY), 32'd1);
    tick();
    last_xfer_cyc = cyc;
    BYTE_VALID = 1'b0;
    BYTE_IN = 8'hxx;
    if (stall) tick();
  endtask

  // Full load of src_q with header n; pushes expected words to the scoreboard.
  task automatic do_load(input int n, input bit stall);
    int wait_cnt = 0;
    int idx = 0;
    pulse_start();
    send_byte(8'(n >> 8), stall);
    send_byte(8'(n), stall);
    foreach (src_q[i]) begin
      send_byte(src_q[i][23:16], stall);
      send_byte(src_q[i][15:8], stall);
      send_byte(src_q[i][7:0], stall);
      if (idx < 256) exp_q.push_back(src_q[i][18:0]);
      idx++;
    end
    while (CPU_RESET && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check_eq("run_reached", 32'(CPU_RESET), 32'd0);
    check_eq("release_len", 32'(cyc - last_xfer_cyc), 32'd1);
    if (!stall) check_eq("min_load_time", 32'(cyc - start_cyc), 32'(3 + 3 * n));
    check_eq("load_done", 32'(LOAD_DONE), 32'd1);
    check_eq("word_count", 32'(WORD_COUNT), (n > 256) ? 32'd256 : 32'(n));
    check_eq("load_err", 32'(LOAD_ERR), (n > 256) ? 32'd1 : 32'd0);
  endtask

  // Drain the scoreboard by fetching PC = 0, 1, ...; then check the bound.
  task automatic verify_mem();
    int pc = 0;
    logic [18:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      PC = 32'(pc);
      #1;
      check_eq($sformatf("instr[%0d]", pc), 32'(INSTRUCTION), 32'(e));
      pc++;
    end
    PC = 32'(pc);
    #1;
    check_eq("instr_past_end", 32'(INSTRUCTION), 32'd0);
    PC = 32'h0001_0000;
    #1;
    check_eq("instr_large_pc", 32'(INSTRUCTION), 32'd0);
    PC = 32'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    RESET = 1'b0;
    // Reset state.
    check_eq("rst_cpu_reset", 32'(CPU_RESET), 32'd1);
    check_eq("rst_byte_ready", 32'(BYTE_READY), 32'd0);
    check_eq("rst_load_done", 32'(LOAD_DONE), 32'd0);
    check_eq("rst_load_err", 32'(LOAD_ERR), 32'd0);
    check_eq("rst_word_count", 32'(WORD_COUNT), 32'd0);
    PC = 32'd0; #1;
    check_eq("rst_instr_pc0", 32'(INSTRUCTION), 32'd0);
    PC = 32'd5; #1;
    check_eq("rst_instr_pc5", 32'(INSTRUCTION), 32'd0);
    PC = 32'd0;

    // N=2, back-to-back stream.
    src_q = '{24'h05A1B2, 24'hF80001};
    do_load(2, 1'b0);
    verify_mem();

    // Same load, BYTE_VALID every other cycle.
    do_load(2, 1'b1);
    verify_mem();

    // Restart from RUN, abort after byte 1 of word 1 with a byte offered
    // together with LOAD_START, then a fresh N=1 load.
    pulse_start();
    check_eq("restart_cpu_reset", 32'(CPU_RESET), 32'd1);
    check_eq("restart_load_done", 32'(LOAD_DONE), 32'd0);
    check_eq("restart_word_count", 32'(WORD_COUNT), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h77, 1'b0);
    BYTE_IN = 8'h55;
    BYTE_VALID = 1'b1;
    src_q = '{24'h012345};
    do_load(1, 1'b0);
    verify_mem();

    // Oversized header: 258 words, only the first 256 kept.
    src_q.delete();
    for (int i = 0; i < 258; i++)
      src_q.push_back({5'($urandom), 19'(i * 32'h9E37 + 32'h155)});
    do_load(258, 1'b0);
    verify_mem();

    // Reset during DATA.
    src_q = '{24'h012345};
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    PC = 32'd0; #1;
    check_eq("midrst_cpu_reset", 32'(CPU_RESET), 32'd1);
    check_eq("midrst_byte_ready", 32'(BYTE_READY), 32'd0);
    check_eq("midrst_word_count", 32'(WORD_COUNT), 32'd0);
    check_eq("midrst_load_err", 32'(LOAD_ERR), 32'd0);
    check_eq("midrst_instr_pc0", 32'(INSTRUCTION), 32'd0);
    tick();
    check_eq("idle_holds_cpu_reset", 32'(CPU_RESET), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
